// File: rtl/ups_load_scheduler.sv
// ups_load_scheduler: UPS outlet power scheduler with battery load shedding and restart debounce.
// Ports: clk_2 (clock), reset (sync, active-high), mains_ok (mains present),
//   req[NOUT] (outlet requests, index 0 highest priority), grant[NOUT] (registered enables),
//   on_battery, shutdown, charge[4] (battery charge), fail_count[4] (mains-loss events),
//   state[2] (MAINS=0, BATTERY=1, SHUTDOWN=2, RESTART=3).
// Define UPS_FAIL_COUNT_EN to implement fail_count; otherwise it is tied to 0.
module ups_load_scheduler #(
  parameter int NOUT = 4,
  parameter int LOW_THR = 3,
  parameter int RESTART_CYC = 3
) (
  input  logic            clk_2,
  input  logic            reset,
  input  logic            mains_ok,
  input  logic [NOUT-1:0] req,
  output logic [NOUT-1:0] grant,
  output logic            on_battery,
  output logic            shutdown,
  output logic [3:0]      charge,
  output logic [3:0]      fail_count,
  output logic [1:0]      state
);
  localparam int RW = $clog2(RESTART_CYC + 1);
  localparam logic [RW-1:0] RC = RW'(RESTART_CYC);
  localparam logic [3:0] LOW = 4'(LOW_THR);
  typedef enum logic [1:0] {MAINS, BATTERY, SHUTDOWN, RESTART} state_t;
  state_t state_q, state_d;
  logic [NOUT-1:0] grant_q, grant_d, lo1, lo2, cap;
  logic [3:0] charge_q, charge_d, charge_inc, charge_dec;
  logic [RW-1:0] rc_q, rc_d;
  logic [4:0] used;
  logic ok_chg;
  // Shed load by priority: keep the one or two lowest-index requests as charge falls.
  always_comb begin
    lo1 = req & (-req);
    lo2 = (req & ~lo1) & (-(req & ~lo1));
    cap = charge_q >= 4'd12 ? req : charge_q >= 4'd8 ? (lo1 | lo2) : lo1;
    ok_chg = charge_q >= LOW;
    charge_inc = charge_q == 4'd15 ? charge_q : charge_q + 4'd1;
    // Drain is charged for the outlets that were actually powered during the last cycle.
    used = 5'($countones(grant_q));
    charge_dec = used > {1'b0, charge_q} ? 4'd0 : 4'(({1'b0, charge_q} - used));
  end
  always_comb begin
    state_d = state_q;
    grant_d = '0;
    charge_d = charge_q;
    rc_d = rc_q;
    case (state_q)
      MAINS: begin
        if (mains_ok) begin
          grant_d = req;
          charge_d = charge_inc;
        end else begin
          state_d = ok_chg ? BATTERY : SHUTDOWN;
          grant_d = ok_chg ? cap : '0;
        end
      end
      BATTERY: begin
        if (mains_ok) begin
          state_d = MAINS;
          grant_d = req;
        end else if (ok_chg) begin
          grant_d = cap;
          charge_d = charge_dec;
        end else begin
          state_d = SHUTDOWN;
        end
      end
      SHUTDOWN: begin
        if (mains_ok) begin
          state_d = RESTART;
          rc_d = RW'(1);
          charge_d = charge_inc;
        end
      end
      RESTART: begin
        if (!mains_ok) begin
          state_d = SHUTDOWN;
          rc_d = '0;
        end else begin
          charge_d = charge_inc;
          state_d = (rc_q == RC && ok_chg) ? MAINS : RESTART;
          rc_d = (rc_q == RC) ? rc_q : rc_q + RW'(1);
        end
      end
    endcase
  end
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q <= SHUTDOWN;
      grant_q <= '0;
      charge_q <= '0;
      rc_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      charge_q <= charge_d;
      rc_q <= rc_d;
    end
  end
`ifdef UPS_FAIL_COUNT_EN
  logic [3:0] fail_q, fail_d;
  always_comb fail_d = (state_q == MAINS && !mains_ok && fail_q != 4'd15) ? fail_q + 4'd1 : fail_q;
  always_ff @(posedge clk_2) begin
    if (reset) fail_q <= '0;
    else fail_q <= fail_d;
  end
  assign fail_count = fail_q;
`else
  assign fail_count = '0;
`endif
  assign grant = grant_q;
  assign charge = charge_q;
  assign state = state_q;
  assign on_battery = state_q == BATTERY;
  assign shutdown = state_q == SHUTDOWN || state_q == RESTART;
endmodule

// File: doc/ups_load_scheduler.md
UPS_LOAD_SCHEDULER -- requirements
Module: ups_load_scheduler

Interface
REQ-001 SHALL have parameter NOUT, default 4, giving the number of outlet requesters; index 0 has the highest priority.
REQ-002 SHALL have parameter LOW_THR, default 3, giving the minimum battery charge allowed for battery operation.
REQ-003 SHALL have parameter RESTART_CYC, default 3, giving the consecutive mains-good cycles required before restart.
REQ-004 SHALL have port clk_2, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port mains_ok, input, 1 bit: 1 when mains power is present.
REQ-007 SHALL have port req, input, NOUT bits: per-outlet power requests.
REQ-008 SHALL have port grant, output, NOUT bits: registered per-outlet power enables.
REQ-009 SHALL have port on_battery, output, 1 bit: high exactly when state is BATTERY.
REQ-010 SHALL have port shutdown, output, 1 bit: high exactly when state is SHUTDOWN or RESTART.
REQ-011 SHALL have port charge, output, 4 bits: battery charge counter.
REQ-012 SHALL have port fail_count, output, 4 bits: count of mains-loss events.
REQ-013 SHALL have port state, output, 2 bits: encoded as MAINS=0, BATTERY=1, SHUTDOWN=2, RESTART=3.

Function
REQ-014 SHALL evaluate every rule below using register values from before the clock edge.
REQ-015 SHALL define cap(req, c) as:
- all requests when c>=12;
- the two lowest-index set requests when 8<=c<=11;
- the lowest-index set request when c<=7.
REQ-016 In MAINS with mains_ok=1:
- SHALL set grant to req;
- SHALL increment charge, saturating at 15.
REQ-017 In MAINS with mains_ok=0:
- SHALL increment fail_count;
- SHALL leave charge unchanged;
- SHALL go to BATTERY with grant=cap(req, charge) if charge>=LOW_THR;
- otherwise SHALL go to SHUTDOWN with grant=0.
REQ-018 In BATTERY with mains_ok=1:
- SHALL go to MAINS with grant=req;
- SHALL leave charge unchanged.
REQ-019 In BATTERY with mains_ok=0 and charge>=LOW_THR:
- SHALL set grant to cap(req, charge);
- SHALL set charge to charge minus popcount(grant), saturating at 0.
REQ-020 In BATTERY with mains_ok=0 and charge<LOW_THR:
- SHALL go to SHUTDOWN;
- SHALL set grant to 0.
REQ-021 In SHUTDOWN:
- SHALL hold grant at 0;
- with mains_ok=1, SHALL go to RESTART, set the restart counter to 1 and increment charge (saturating);
- with mains_ok=0, SHALL leave charge unchanged.
REQ-022 In RESTART with mains_ok=0:
- SHALL go to SHUTDOWN;
- SHALL clear the restart counter.
REQ-023 In RESTART with mains_ok=1:
- SHALL go to MAINS, with grant still 0 on that edge, when restart counter==RESTART_CYC and charge>=LOW_THR;
- otherwise SHALL increment the restart counter, saturating at RESTART_CYC;
- in both cases SHALL increment charge, saturating at 15.
REQ-024 SHALL saturate fail_count at 15.
REQ-025 SHALL never assert a grant bit whose req bit was 0 before the edge.

Reset
REQ-026 With reset=1 at an edge, SHALL set state=SHUTDOWN, grant=0, charge=0, fail_count=0 and restart counter=0, regardless of state (including mid-BATTERY).
REQ-027 SHALL give reset priority over all other inputs.

Configuration
REQ-028 With macro UPS_FAIL_COUNT_EN defined, SHALL implement fail_count as in REQ-017 and REQ-024.
REQ-029 Without UPS_FAIL_COUNT_EN, SHALL omit the fail counter, tie fail_count to 0, and leave all other behaviour unchanged.

Verification
REQ-030 Reset, then mains_ok=1 and req=4'b1111: shutdown SHALL be 1 through edge 3, shutdown=0 and state=MAINS with charge=4 after edge 4, and grant=4'b1111 after edge 5.
REQ-031 From MAINS with charge=15, req=4'b1111, drop mains_ok:
- after edge 1: on_battery=1, fail_count=1, grant=1111, charge=15;
- charge then falls 11, 7, 5, 4, 3, 2;
- grant then goes 1111, 0011, 0001;
- after edge 8: state=SHUTDOWN, grant=0.
REQ-032 In BATTERY with charge=10 and req=4'b0110, raise mains_ok: after the next edge, state=MAINS, on_battery=0, grant=4'b0110.
REQ-033 In RESTART with counter=2, drop mains_ok for one cycle: state SHALL return to SHUTDOWN and a full RESTART_CYC sequence SHALL be required again.
REQ-034 Apply 17 mains-loss events: fail_count SHALL be 15 with UPS_FAIL_COUNT_EN defined and 0 without it.
REQ-035 Assert reset while in BATTERY with grant=4'b0011: after the edge, state=2, grant=0, charge=0.
